// File: rtl/main_fsm.sv
// main_fsm: multicycle Moore sequencer for the datapath (fetch/decode/execute/
// memory/writeback), fixed-latency multiplier step and start/done FPU step.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   Op, Funct  instruction fields Instr[27:26], Instr[25:20]
//   IsMul      decoded multiply, IsFpu decoded FPU op (sampled in DECODE)
//   FPUDone    FPU result valid (sampled in FPUEX)
//   IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc   datapath strobes
//   ALUSrcA, ALUSrcB, ResultSrc                          datapath mux selects
//   FPUStart   one-cycle FPU launch, Fault sticky fault flag
//   State      current state encoding for debug
module main_fsm #(
    parameter int MUL_CYCLES  = 4,
    parameter int FPU_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       IsMul,
    input  logic       IsFpu,
    input  logic       FPUDone,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       FPUStart,
    output logic       Fault,
    output logic [3:0] State
);

    localparam int MW = $clog2(MUL_CYCLES + 1);
    localparam int FW = $clog2(FPU_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_MULEX    = 4'd10,
        S_FPUEX    = 4'd11,
        S_XWB      = 4'd12,
        S_UNKNOWN  = 4'd15
    } state_t;

    state_t        r_state;
    state_t        w_next;
    // r_run stays low until the first edge after reset release, so the
    // outputs (all register decodes) read 0 throughout reset.
    logic          r_run;
    logic [MW-1:0] r_mcnt;
    logic [MW-1:0] w_mcnt_next;
    logic [FW-1:0] r_fcnt;
    logic [FW-1:0] w_fcnt_next;
    logic          r_fault;
    logic          w_unused;

    assign w_unused = ^Funct[4:1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_run   <= 1'b0;
            r_mcnt  <= '0;
            r_fcnt  <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
            r_mcnt  <= w_mcnt_next;
            r_fcnt  <= w_fcnt_next;
            if (r_run && w_next == S_UNKNOWN)
                r_fault <= 1'b1;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_mcnt_next = r_mcnt;
        w_fcnt_next = r_fcnt;
        if (!r_run) begin
            w_next = S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    w_next = S_DECODE;
                S_DECODE: begin
                    if (Op == 2'b01) begin
                        w_next = S_MEMADR;
                    end else if (Op == 2'b10) begin
                        w_next = S_BRANCH;
                    end else if (Op == 2'b00) begin
                        if (IsMul) begin
                            w_next      = S_MULEX;
                            w_mcnt_next = MW'(MUL_CYCLES - 1);
                        end else if (Funct[5]) begin
                            w_next = S_EXECI;
                        end else begin
                            w_next = S_EXECR;
                        end
                    end else if (IsFpu) begin
                        // fcnt holds the 1-based index of the FPUEX cycle
                        w_next      = S_FPUEX;
                        w_fcnt_next = FW'(1);
                    end else begin
                        w_next = S_UNKNOWN;
                    end
                end
                S_MEMADR:   w_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  w_next = S_MEMWB;
                S_MEMWB:    w_next = S_FETCH;
                S_MEMWRITE: w_next = S_FETCH;
                S_EXECR:    w_next = S_ALUWB;
                S_EXECI:    w_next = S_ALUWB;
                S_ALUWB:    w_next = S_FETCH;
                S_BRANCH:   w_next = S_FETCH;
                S_MULEX: begin
                    if (r_mcnt == '0)
                        w_next = S_XWB;
                    else
                        w_mcnt_next = r_mcnt - MW'(1);
                end
                S_FPUEX: begin
                    // done on the final cycle still wins over the timeout
                    if (FPUDone) begin
                        w_next      = S_XWB;
                        w_fcnt_next = '0;
                    end else if (r_fcnt == FW'(FPU_TIMEOUT)) begin
                        w_next      = S_UNKNOWN;
                        w_fcnt_next = '0;
                    end else begin
                        w_fcnt_next = r_fcnt + FW'(1);
                    end
                end
                S_XWB:      w_next = S_FETCH;
                S_UNKNOWN:  w_next = S_UNKNOWN;
                default:    w_next = S_UNKNOWN;
            endcase
        end
    end

    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        FPUStart  = 1'b0;
        if (r_run) begin
            case (r_state)
                S_FETCH: begin
                    IRWrite   = 1'b1;
                    NextPC    = 1'b1;
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                S_DECODE: begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                S_MEMADR:   ALUSrcB = 2'b01;
                S_MEMREAD:  AdrSrc  = 1'b1;
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegW      = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc = 1'b1;
                    MemW   = 1'b1;
                end
                S_EXECR:    ALUOp = 1'b1;
                S_EXECI: begin
                    ALUOp   = 1'b1;
                    ALUSrcB = 2'b01;
                end
                S_ALUWB:    RegW = 1'b1;
                S_BRANCH: begin
                    ALUSrcA   = 2'b10;
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    Branch    = 1'b1;
                end
                S_FPUEX:    FPUStart = (r_fcnt == FW'(1));
                S_XWB: begin
                    ResultSrc = 2'b11;
                    RegW      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Fault = r_fault;
    assign State = r_state;

endmodule
